// File: rtl/router_reg.sv
// Datapath/register slice of a 1x3 packet router: header latch, FIFO stall buffer, byte stream and parity check.
// Optional parity checking is built when ROUTER_REG_PARITY_ERR_EN is defined; otherwise err is tied low.
module router_reg #(
   parameter int DATA_WIDTH = 8
) (
   input  logic                  clock,
   input  logic                  resetn,
   input  logic                  pkt_valid,
   input  logic [DATA_WIDTH-1:0] data_in,
   input  logic                  fifo_full,
   input  logic                  detect_add,
   input  logic                  ld_state,
   input  logic                  laf_state,
   input  logic                  full_state,
   input  logic                  lfd_state,
   input  logic                  rst_int_reg,
   output logic                  err,
   output logic                  parity_done,
   output logic                  low_pkt_valid,
   output logic [DATA_WIDTH-1:0] dout
);

   logic [DATA_WIDTH-1:0] header_q, header_d;
   logic [DATA_WIDTH-1:0] full_byte_q, full_byte_d;
   logic [DATA_WIDTH-1:0] dout_q, dout_d;
   logic                  low_pkt_valid_q, low_pkt_valid_d;
   logic                  parity_done_q, parity_done_d;

   // Address 2'b11 has no output port, so such a header is never latched.
   always_comb begin
      header_d = header_q;
      if (detect_add && pkt_valid && (data_in[1:0] != 2'b11))
         header_d = data_in;
   end

   always_comb begin
      dout_d = dout_q;
      if (lfd_state)
         dout_d = header_q;
      else if (ld_state && !fifo_full)
         dout_d = data_in;
      else if (laf_state)
         dout_d = full_byte_q;
   end

   // One-byte park slot: the byte offered while the FIFO was full is replayed in LOAD_AFTER_FULL.
   always_comb begin
      full_byte_d = full_byte_q;
      if (ld_state && fifo_full)
         full_byte_d = data_in;
   end

   always_comb begin
      low_pkt_valid_d = low_pkt_valid_q;
      if (rst_int_reg)
         low_pkt_valid_d = 1'b0;
      else if (ld_state && !pkt_valid)
         low_pkt_valid_d = 1'b1;
   end

   // A parity byte parked in full_byte completes the packet when it is replayed.
   always_comb begin
      parity_done_d = parity_done_q;
      if (detect_add)
         parity_done_d = 1'b0;
      else if (ld_state && !fifo_full && !pkt_valid)
         parity_done_d = 1'b1;
      else if (laf_state && low_pkt_valid_q && !parity_done_q)
         parity_done_d = 1'b1;
   end

   always_ff @(posedge clock or posedge resetn) begin
      if (resetn) begin
         header_q        <= '0;
         full_byte_q     <= '0;
         dout_q          <= '0;
         low_pkt_valid_q <= 1'b0;
         parity_done_q   <= 1'b0;
      end else begin
         header_q        <= header_d;
         full_byte_q     <= full_byte_d;
         dout_q          <= dout_d;
         low_pkt_valid_q <= low_pkt_valid_d;
         parity_done_q   <= parity_done_d;
      end
   end

`ifdef ROUTER_REG_PARITY_ERR_EN
   logic [DATA_WIDTH-1:0] int_parity_q, int_parity_d;
   logic [DATA_WIDTH-1:0] pkt_parity_q, pkt_parity_d;
   logic                  err_q, err_d;

   always_comb begin
      int_parity_d = int_parity_q;
      if (detect_add)
         int_parity_d = '0;
      else if (lfd_state)
         int_parity_d = int_parity_q ^ header_q;
      else if (ld_state && pkt_valid && !full_state)
         int_parity_d = int_parity_q ^ data_in;
   end

   always_comb begin
      pkt_parity_d = pkt_parity_q;
      if (detect_add)
         pkt_parity_d = '0;
      else if (ld_state && !pkt_valid && !fifo_full)
         pkt_parity_d = data_in;
   end

   // Compared off the registered parity_done, so err lands one cycle after it.
   always_comb begin
      err_d = err_q;
      if (detect_add)
         err_d = 1'b0;
      else if (parity_done_q)
         err_d = (int_parity_q != pkt_parity_q);
   end

   always_ff @(posedge clock or posedge resetn) begin
      if (resetn) begin
         int_parity_q <= '0;
         pkt_parity_q <= '0;
         err_q        <= 1'b0;
      end else begin
         int_parity_q <= int_parity_d;
         pkt_parity_q <= pkt_parity_d;
         err_q        <= err_d;
      end
   end

   assign err = err_q;
`else
   logic unused_full_state;
   assign unused_full_state = full_state;
   assign err               = 1'b0;
`endif

   assign dout          = dout_q;
   assign parity_done   = parity_done_q;
   assign low_pkt_valid = low_pkt_valid_q;

endmodule

// File: tb/tb_router_reg.sv
// Scoreboard bench for router_reg: expected dout bytes are queued as stimulus is driven and popped after each edge.
module tb_router_reg;

   logic       clock = 1'b0;
   logic       resetn, pkt_valid, fifo_full, rst_int_reg;
   logic       detect_add, ld_state, laf_state, full_state, lfd_state;
   logic [7:0] data_in;
   logic       err, parity_done, low_pkt_valid;
   logic [7:0] dout;

`ifdef ROUTER_REG_PARITY_ERR_EN
   localparam bit ERR_EN = 1'b1;
`else
   localparam bit ERR_EN = 1'b0;
`endif

   localparam logic [4:0] S_IDLE = 5'b00000;
   localparam logic [4:0] S_DA   = 5'b10000;
   localparam logic [4:0] S_LFD  = 5'b01000;
   localparam logic [4:0] S_LD   = 5'b00100;
   localparam logic [4:0] S_FULL = 5'b00010;
   localparam logic [4:0] S_LAF  = 5'b00001;

   router_reg #(.DATA_WIDTH(8)) dut (
      .clock(clock), .resetn(resetn), .pkt_valid(pkt_valid), .data_in(data_in),
      .fifo_full(fifo_full), .detect_add(detect_add), .ld_state(ld_state),
      .laf_state(laf_state), .full_state(full_state), .lfd_state(lfd_state),
      .rst_int_reg(rst_int_reg), .err(err), .parity_done(parity_done),
      .low_pkt_valid(low_pkt_valid), .dout(dout)
   );

   always #5 clock = ~clock;

   int         checks = 0;
   int         failures = 0;
   logic [7:0] exp_q[$];
   logic [7:0] last_hdr;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Drive one cycle; when has_exp is set the byte e must appear on dout after the edge.
   task automatic cyc(input logic [4:0] st, input logic pv, input logic [7:0] d, input logic ff,
                      input logic ri, input bit has_exp, input logic [7:0] e);
      {detect_add, lfd_state, ld_state, full_state, laf_state} = st;
      pkt_valid   = pv;
      data_in     = d;
      fifo_full   = ff;
      rst_int_reg = ri;
      if (has_exp) exp_q.push_back(e);
      @(posedge clock);
      #1;
      if (has_exp) begin
         if (exp_q.size() == 0) chk("dout_q_empty", 32'd0, 32'd1);
         else chk("dout", dout, exp_q.pop_front());
      end
   endtask

   // stall_at < len stalls that payload byte; stall_at == len stalls the parity byte.
   task automatic send_pkt(input logic [7:0] hdr, input bit bad, input int stall_at);
      logic [5:0] len;
      logic [7:0] par, p, prev, pb;
      len = hdr[7:2];
      cyc(S_DA, 1'b1, hdr, 1'b0, 1'b0, 1'b0, 8'h00);
      chk("err_clr", err, 1'b0);
      chk("pdone_clr", parity_done, 1'b0);
      cyc(S_LFD, 1'b1, 8'h00, 1'b0, 1'b0, 1'b1, hdr);
      chk("low_pre", low_pkt_valid, 1'b0);
      last_hdr = hdr;
      par  = hdr;
      prev = hdr;
      for (int i = 0; i < int'(len); i++) begin
         p   = 8'($urandom_range(0, 255));
         par = par ^ p;
         if (i == stall_at) begin
            cyc(S_LD,   1'b1, p, 1'b1, 1'b0, 1'b1, prev);
            cyc(S_FULL, 1'b1, p, 1'b1, 1'b0, 1'b1, prev);
            cyc(S_LAF,  1'b1, p, 1'b0, 1'b0, 1'b1, p);
         end else begin
            cyc(S_LD, 1'b1, p, 1'b0, 1'b0, 1'b1, p);
         end
         prev = p;
      end
      pb = bad ? (par ^ 8'h01) : par;
      if (stall_at == int'(len)) begin
         cyc(S_LD, 1'b0, pb, 1'b1, 1'b0, 1'b1, prev);
         chk("pdone_stall", parity_done, 1'b0);
         chk("low_stall", low_pkt_valid, 1'b1);
         cyc(S_FULL, 1'b0, pb, 1'b1, 1'b0, 1'b1, prev);
         cyc(S_LAF,  1'b0, pb, 1'b0, 1'b0, 1'b1, pb);
         chk("pdone_laf", parity_done, 1'b1);
         // Parked parity byte never reaches pkt_parity, so the compare is against zero.
         cyc(S_IDLE, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, pb);
         chk("err_laf", err, ERR_EN && (par != 8'h00));
      end else begin
         cyc(S_LD, 1'b0, pb, 1'b0, 1'b0, 1'b1, pb);
         chk("pdone", parity_done, 1'b1);
         chk("low_set", low_pkt_valid, 1'b1);
         cyc(S_IDLE, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, pb);
         chk("err", err, ERR_EN && bad);
      end
      chk("low_rst_int", low_pkt_valid, 1'b0);
      cyc(S_IDLE, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, pb);
      chk("err_hold", err, ERR_EN && ((stall_at == int'(len)) ? (par != 8'h00) : bad));
      chk("pdone_hold", parity_done, 1'b1);
   endtask

   initial begin
      resetn = 1'b1;
      {detect_add, lfd_state, ld_state, full_state, laf_state} = S_IDLE;
      pkt_valid = 1'b0; data_in = 8'h00; fifo_full = 1'b0; rst_int_reg = 1'b0;
      repeat (2) @(posedge clock);
      #1;
      chk("rst_err", err, 1'b0);
      chk("rst_pdone", parity_done, 1'b0);
      chk("rst_low", low_pkt_valid, 1'b0);
      chk("rst_dout", dout, 8'h00);
      resetn = 1'b0;

      send_pkt(8'h3D, 1'b0, -1);
      send_pkt(8'h3D, 1'b1, -1);
      send_pkt(8'h1A, 1'b0, 2);
      send_pkt(8'h0C, 1'b0, 3);

      // Address 3 header must leave header_reg alone.
      cyc(S_DA, 1'b1, 8'h3F, 1'b0, 1'b0, 1'b0, 8'h00);
      chk("err_da3", err, 1'b0);
      cyc(S_LFD, 1'b1, 8'h00, 1'b0, 1'b0, 1'b1, last_hdr);
      cyc(S_LD, 1'b1, 8'hA5, 1'b0, 1'b0, 1'b1, 8'hA5);
      cyc(S_LD, 1'b0, 8'h5A, 1'b0, 1'b0, 1'b1, 8'h5A);
      chk("pdone_pre_ar", parity_done, 1'b1);

      // Asynchronous reset between edges.
      #2;
      resetn = 1'b1;
      #1;
      chk("ar_err", err, 1'b0);
      chk("ar_pdone", parity_done, 1'b0);
      chk("ar_low", low_pkt_valid, 1'b0);
      chk("ar_dout", dout, 8'h00);
      @(negedge clock);
      resetn = 1'b0;
      cyc(S_LFD, 1'b1, 8'h00, 1'b0, 1'b0, 1'b1, 8'h00);
      cyc(S_LAF, 1'b1, 8'h00, 1'b0, 1'b0, 1'b1, 8'h00);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout got=0 exp=1");
      $fatal(1);
   end

endmodule
